// File: rtl/cw_trace_pkg.sv
// Shared definitions for the control-word trace buffer: FSM encoding, control-word
// field positions and trace-entry field positions.
package cw_trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } trace_state_e;

    // Control-word field positions (shared with the processor and its benches)
    localparam int R_ADDR_MSB = 36;
    localparam int R_ADDR_LSB = 32;
    localparam int A_ADDR_MSB = 31;
    localparam int A_ADDR_LSB = 27;
    localparam int B_ADDR_MSB = 26;
    localparam int B_ADDR_LSB = 22;
    localparam int FS_MSB     = 18;
    localparam int FS_LSB     = 14;
    localparam int PS_MSB     = 7;
    localparam int PS_LSB     = 6;

    // Trace-entry layout: {rom_addr, r_addr, a_addr, b_addr, fs, ps}
    localparam int FIELDS_W   = 22;
    localparam int E_PS_LSB   = 0;
    localparam int E_FS_LSB   = 2;
    localparam int E_B_LSB    = 7;
    localparam int E_A_LSB    = 12;
    localparam int E_R_LSB    = 17;
    localparam int E_ROM_LSB  = 22;

endpackage

// File: rtl/cw_trace_buffer_ram.sv
// Simple dual-port trace RAM: synchronous write, registered synchronous read that
// holds its last value when no read is requested. Contents are not reset.
module trace_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 54,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/cw_trace_buffer.sv
// Breakpoint-triggered trace buffer: captures ROM address and decoded control-word
// fields every cycle into a circular RAM, then plays the history back oldest-first.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | nothing captured, waiting for arm
//   ST_ARMED | capturing every cycle, watching for the breakpoint address
//   ST_POST  | capturing the remaining post-trigger samples
//   ST_DONE  | capture frozen, rd_en plays entries back oldest-first
module cw_trace_buffer
    import cw_trace_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 32,
    parameter int CW_W    = 37,
    parameter int ENTRY_W = ADDR_W + 22,
    parameter int PW      = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               arm,
    input  logic [ADDR_W-1:0]  trig_addr,
    input  logic [PW-1:0]      post_count,
    input  logic [ADDR_W-1:0]  rom_addr,
    input  logic [CW_W-1:0]    cw,
    input  logic               rd_en,
    output logic [ENTRY_W-1:0] rd_data,
    output logic               rd_valid,
    output logic [1:0]         state,
    output logic               triggered,
    output logic [PW-1:0]      count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [PW-1:0] FULL     = PW'(DEPTH);
    localparam logic [PW-1:0] MAX_POST = PW'(DEPTH - 1);

    trace_state_e     state_q, state_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    count_q, count_d;
    logic [PW-1:0]    rd_cnt_q, rd_cnt_d;
    logic [PW-1:0]    remaining_q, remaining_d;
    logic [PW-1:0]    post_lat_q, post_lat_d;
    logic             triggered_q, triggered_d;
    logic             rd_valid_q, rd_valid_d;
    logic             rd_seen_q, rd_seen_d;

    logic             ram_we, ram_re, done_now;
    logic [ENTRY_W-1:0] entry, ram_rdata;
    logic             cw_unused;

    assign entry = {rom_addr,
                    cw[R_ADDR_MSB:R_ADDR_LSB],
                    cw[A_ADDR_MSB:A_ADDR_LSB],
                    cw[B_ADDR_MSB:B_ADDR_LSB],
                    cw[FS_MSB:FS_LSB],
                    cw[PS_MSB:PS_LSB]};
    assign cw_unused = ^{cw[B_ADDR_LSB-1:FS_MSB+1], cw[FS_LSB-1:PS_MSB+1], cw[PS_LSB-1:0]};

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        rd_cnt_d    = rd_cnt_q;
        remaining_d = remaining_q;
        post_lat_d  = post_lat_q;
        triggered_d = triggered_q;
        rd_seen_d   = rd_seen_q;
        rd_valid_d  = 1'b0;
        ram_we      = 1'b0;
        ram_re      = 1'b0;
        done_now    = 1'b0;

        if (arm) begin
            // arm outranks everything, including a coincident read
            state_d     = ST_ARMED;
            count_d     = '0;
            triggered_d = 1'b0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            rd_cnt_d    = '0;
            post_lat_d  = (post_count > MAX_POST) ? MAX_POST : post_count;
        end else begin
            case (state_q)
                ST_ARMED, ST_POST: begin
                    ram_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (count_q != FULL) begin
                        count_d = count_q + 1'b1;
                    end
                    if (state_q == ST_ARMED) begin
                        if (rom_addr == trig_addr) begin
                            triggered_d = 1'b1;
                            remaining_d = post_lat_q;
                            if (post_lat_q == '0) begin
                                done_now = 1'b1;
                            end else begin
                                state_d = ST_POST;
                            end
                        end
                    end else begin
                        remaining_d = remaining_q - 1'b1;
                        if (remaining_q == PW'(1)) begin
                            done_now = 1'b1;
                        end
                    end
                    if (done_now) begin
                        // once wrapped, the next write slot holds the oldest entry
                        state_d  = ST_DONE;
                        rd_ptr_d = (count_d == FULL) ? wr_ptr_d : '0;
                        rd_cnt_d = '0;
                    end
                end
                ST_DONE: begin
                    if (rd_en && (rd_cnt_q != count_q)) begin
                        ram_re     = 1'b1;
                        rd_ptr_d   = rd_ptr_q + 1'b1;
                        rd_cnt_d   = rd_cnt_q + 1'b1;
                        rd_valid_d = 1'b1;
                        rd_seen_d  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_cnt_q    <= '0;
            remaining_q <= '0;
            post_lat_q  <= '0;
            triggered_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_seen_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_cnt_q    <= rd_cnt_d;
            remaining_q <= remaining_d;
            post_lat_q  <= post_lat_d;
            triggered_q <= triggered_d;
            rd_valid_q  <= rd_valid_d;
            rd_seen_q   <= rd_seen_d;
        end
    end

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr_q),
        .wdata (entry),
        .re    (ram_re),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    // RAM output is unreset, so rd_data reads as zero until the first read after reset
    assign rd_data   = rd_seen_q ? ram_rdata : '0;
    assign rd_valid  = rd_valid_q;
    assign state     = state_q;
    assign triggered = triggered_q;
    assign count     = count_q;

endmodule

// File: tb/tb_cw_trace_buffer.sv
// Scoreboard bench for cw_trace_buffer: reads push expected entries, a negedge monitor
// pops and compares whenever rd_valid is seen.
module tb_cw_trace_buffer;

    localparam int DEPTH   = 16;
    localparam int ADDR_W  = 32;
    localparam int CW_W    = 37;
    localparam int ENTRY_W = ADDR_W + 22;
    localparam int PW      = $clog2(DEPTH) + 1;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               arm = 1'b0;
    logic [ADDR_W-1:0]  trig_addr = '0;
    logic [PW-1:0]      post_count = '0;
    logic [ADDR_W-1:0]  rom_addr = '0;
    logic [CW_W-1:0]    cw = '0;
    logic               rd_en = 1'b0;
    logic [ENTRY_W-1:0] rd_data;
    logic               rd_valid;
    logic [1:0]         state;
    logic               triggered;
    logic [PW-1:0]      count;

    int pass_cnt = 0;
    int total_cnt = 0;
    bit use_fixed = 1'b0;
    logic [ENTRY_W-1:0] exp_q[$];

    cw_trace_buffer #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .CW_W   (CW_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .arm        (arm),
        .trig_addr  (trig_addr),
        .post_count (post_count),
        .rom_addr   (rom_addr),
        .cw         (cw),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .state      (state),
        .triggered  (triggered),
        .count      (count)
    );

    always #5 clk = ~clk;

    function automatic logic [CW_W-1:0] cw_of(input logic [31:0] a);
        logic [4:0] l;
        l = a[4:0];
        if (use_fixed) return 37'h1F_F800_0000;
        return {l, ~l, l ^ 5'h15, 3'b111, l + 5'd3, 6'h3F, a[1:0], 6'h3F};
    endfunction

    function automatic logic [ENTRY_W-1:0] exp_entry(input logic [31:0] a);
        logic [4:0] l;
        l = a[4:0];
        if (use_fixed) return {a, 22'h3FF000};
        return {a, l, ~l, l ^ 5'h15, l + 5'd3, a[1:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_rd_valid: got rd_valid=1 data=%0h expected no read", rd_data);
            end else begin
                chk("rd_data", 64'(rd_data), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic set_addr(input logic [31:0] a);
        rom_addr = a;
        cw = cw_of(a);
    endtask

    task automatic start_arm(input logic [31:0] trig, input int post);
        @(negedge clk);
        arm = 1'b1;
        trig_addr = trig;
        post_count = PW'(post);
        @(negedge clk);
        arm = 1'b0;
        set_addr(0);
    endtask

    // Advances rom_addr one per cycle until DONE; optionally pokes rd_en while capturing.
    task automatic run_to_done(input bit poke_rd);
        bit done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (poke_rd && i == 2) chk("rd_en_armed_ignored", 64'(rd_valid), 64'd0);
            rd_en = (poke_rd && i == 1);
            if (state == 2'd3) done = 1'b1;
            else set_addr(rom_addr + 1);
        end
        rd_en = 1'b0;
        if (!done) chk("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic read_check(input logic [31:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 1) chk("rd_latency_1", 64'(rd_valid), 64'd1);
            rd_en = 1'b1;
            exp_q.push_back(exp_entry(first + 32'(i)));
        end
        @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        chk("extra_read_valid", 64'(rd_valid), 64'd0);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_state", 64'(state), 64'd0);
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_triggered", 64'(triggered), 64'd0);
        chk("reset_rd_valid", 64'(rd_valid), 64'd0);
        chk("reset_rd_data", 64'(rd_data), 64'd0);
        rst = 1'b0;

        // basic: trigger 5, three post samples
        start_arm(5, 3);
        run_to_done(1'b0);
        chk("basic_done_addr", 64'(rom_addr), 64'd8);
        chk("basic_count", 64'(count), 64'd9);
        chk("basic_triggered", 64'(triggered), 64'd1);
        read_check(0, 9);

        // wrap: trigger 40, four post samples, oldest is 29
        start_arm(40, 4);
        run_to_done(1'b0);
        chk("wrap_done_addr", 64'(rom_addr), 64'd44);
        chk("wrap_count", 64'(count), 64'd16);
        read_check(29, 16);

        // post_count 0: done on the trigger edge
        start_arm(2, 0);
        run_to_done(1'b0);
        chk("post0_done_addr", 64'(rom_addr), 64'd2);
        chk("post0_count", 64'(count), 64'd3);
        read_check(0, 3);

        // post_count 20 clamps to 15
        start_arm(2, 20);
        run_to_done(1'b0);
        chk("clamp_done_addr", 64'(rom_addr), 64'd17);
        chk("clamp_count", 64'(count), 64'd16);
        read_check(2, 16);

        // fixed control-word field pattern; rd_en while ARMED ignored
        use_fixed = 1'b1;
        start_arm(3, 0);
        run_to_done(1'b1);
        chk("fixed_count", 64'(count), 64'd4);
        read_check(0, 4);
        use_fixed = 1'b0;

        // reset in the middle of POST
        start_arm(3, 10);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            set_addr(k);
        end
        @(negedge clk);
        chk("mid_post_state", 64'(state), 64'd2);
        chk("mid_post_count", 64'(count), 64'd7);
        rst = 1'b1;
        #1;
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_triggered", 64'(triggered), 64'd0);
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        chk("rd_after_rst", 64'(rd_valid), 64'd0);

        // arm during POST restarts the capture
        start_arm(2, 10);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            set_addr(k);
        end
        @(negedge clk);
        chk("pre_rearm_state", 64'(state), 64'd2);
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        chk("rearm_state", 64'(state), 64'd1);
        chk("rearm_count", 64'(count), 64'd0);
        chk("rearm_triggered", 64'(triggered), 64'd0);
        set_addr(0);
        run_to_done(1'b0);
        chk("rearm_done_addr", 64'(rom_addr), 64'd12);
        chk("rearm_done_count", 64'(count), 64'd13);

        // arm and rd_en together in DONE: restart, read dropped
        @(negedge clk);
        arm = 1'b1;
        rd_en = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        rd_en = 1'b0;
        chk("arm_rd_state", 64'(state), 64'd1);
        chk("arm_rd_valid", 64'(rd_valid), 64'd0);
        @(negedge clk);
        chk("final_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/cw_trace_buffer.md
# cw_trace_buffer

Synthesisable, parametrised on-chip trace buffer for the microprogrammed processor. Each cycle it captures the ROM address and the decoded control-word fields (r_addr, a_addr, b_addr, fs, ps) into a circular RAM. Capture stops a programmable number of samples after a ROM-address breakpoint. Software or a bench then reads the history oldest-first, replacing hierarchical probing of the processor with a reusable, depth-configurable observer.

## Interface
- DEPTH, 16, entries in the trace RAM; power of two, at least 4
- ADDR_W, 32, ROM address width
- CW_W, 37, control-word width; fields at fixed offsets: r_addr [36:32], a_addr [31:27], b_addr [26:22], fs [18:14], ps [7:6]
- ENTRY_W, ADDR_W+22, derived width of one entry: {rom_addr, r_addr, a_addr, b_addr, fs, ps}, with rom_addr in the MSBs
- PW, $clog2(DEPTH)+1, derived counter width

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- arm  in  1  single-cycle pulse; starts or restarts a capture
- trig_addr  in  ADDR_W  breakpoint ROM address
- post_count  in  PW  samples to take after the trigger sample; sampled only on arm
- rom_addr  in  ADDR_W  processor ROM address (observed)
- cw  in  CW_W  processor control word (observed)
- rd_en  in  1  read request; honoured in DONE only
- rd_data  out  ENTRY_W  read entry
- rd_valid  out  1  rd_data valid
- state  out  2  IDLE=0, ARMED=1, POST=2, DONE=3
- triggered  out  1  breakpoint has been hit in the current capture
- count  out  PW  valid entries, saturating at DEPTH

## Operation
- Reset (async) sets state=IDLE, count=0, triggered=0, rd_valid=0, rd_data=0, all pointers=0. RAM contents are not reset.
- **IDLE:** nothing is written. An arm pulse moves to ARMED, clears count, triggered, wr_ptr, and rd_ptr, and latches post_lat=min(post_count, DEPTH-1).
- **ARMED:** every edge writes the current entry at wr_ptr and increments wr_ptr modulo DEPTH.
  - count increments, saturating at DEPTH.
  - If rom_addr==trig_addr on that edge, the written entry is the trigger sample and triggered becomes 1.
  - Next state is DONE if post_lat==0, otherwise POST with remaining=post_lat.
- **POST:** every edge writes an entry exactly as in ARMED and decrements remaining. The edge that writes with remaining==1 moves to DONE. Further address matches are ignored.
- **DONE:** writing stops.
  - On entry, rd_ptr is set to (count==DEPTH) ? wr_ptr : 0, which is the oldest entry.
  - Each rd_en reads RAM[rd_ptr] and advances rd_ptr modulo DEPTH.
  - After count reads, further rd_en returns rd_valid=0 and rd_data holds its value.
- arm in any state restarts the capture as in IDLE. When arm and rd_en coincide, arm wins and the read is dropped.
- rd_en outside DONE is ignored, and rd_valid stays 0.
- Reset mid-capture returns to IDLE immediately. count is cleared, so previously captured data is unreadable.

## Timing
- State changes on the edge that samples the cause.
- The first captured sample is the edge after the arm edge.
- Total samples after the trigger = post_lat. The trigger sample is always the entry at position count-1-post_lat in read order.
- Read latency is 1 cycle: rd_en sampled at edge N gives rd_valid=1 and rd_data after edge N. rd_valid is a 1-cycle pulse per accepted request.
- Back-to-back rd_en every cycle gives one entry per cycle.
- A RAM write and a read never occur in the same cycle, so there is no bypass.
- Wrap-around: in ARMED, the oldest entry is overwritten continuously. There is no overflow flag; count saturates at DEPTH.

## Structure
- Shared package cw_trace_pkg holds:
  - the state encoding constants
  - the cw field offsets/widths (R_ADDR_MSB/LSB, A_ADDR, B_ADDR, FS, PS)
  - the entry field offsets
- The processor and its benches reuse the same field offsets.
- There is one sub-module, trace_ram: simple dual-port, DEPTH x ENTRY_W, synchronous write, registered synchronous read, no reset.
- The top level holds the FSM, pointers, count/remaining counters and entry packing.

## Test plan
- Reset mid-POST with count=7 → state=0, count=0, triggered=0, rd_valid=0 while rst is high; rd_en afterwards yields no rd_valid.
- DEPTH=16, arm, post_count=3, rom_addr counts 0,1,2,…; trig_addr=5 → DONE after the sample with rom_addr=8, count=9; 9 reads return rom_addr 0..8 with rd_valid one cycle after each rd_en; a 10th read gives rd_valid=0.
- Same test with trig_addr=40, post_count=4 → wrap; count=16; reads return rom_addr 29..44 oldest-first; the trigger (40) is entry index 11.
- post_count=0, trig_addr=2 → DONE on the trigger edge; count=3; the last entry read has rom_addr=2; post_count=20 with DEPTH=16 behaves as 15.
- cw=37'h1F_F800_0000-style field patterns → rd_data fields match r_addr, a_addr, b_addr, fs, ps bit-for-bit; a rd_en while ARMED is ignored.
- arm pulse during POST → restart: count=0, triggered=0, state=ARMED next cycle; arm and rd_en together in DONE → restart and no rd_valid.
